// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - double-buffered common-anode N-digit 7-segment scan driver
// Optional brightness control enabled by defining SEG7_DIMMING_EN (adds duty[3:0]).
module seg7_scan_mux #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 27000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  load,
`ifdef SEG7_DIMMING_EN
    input  logic [3:0]            duty,
`endif
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int DW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  leave_show;
    logic                  last_digit;
    logic                  swap;

    logic [7*N_DIGITS-1:0] pend_seg_q, act_seg_q;
    logic [N_DIGITS-1:0]   pend_en_q, act_en_q;
    logic                  pend_valid_q;

    logic [6:0]            seg_d;
    logic [N_DIGITS-1:0]   an_d;
    logic                  lit;

    assign last_digit = (idx_q == IW'(N_DIGITS - 1));
    assign frame_done = leave_show && last_digit;
    assign swap       = frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            div_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q + DW'(1);
        idx_d      = idx_q;
        leave_show = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (div_q == DW'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    div_d   = '0;
                end
            end
            ST_SHOW: begin
                if (div_q == DW'(REFRESH_DIV - 1)) begin
                    state_d    = ST_BLANK;
                    div_d      = '0;
                    leave_show = 1'b1;
                    idx_d      = last_digit ? '0 : idx_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                div_d   = '0;
            end
        endcase
    end

    // A load landing on the swap cycle bypasses pending so fresh data is never a frame late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_seg_q   <= {N_DIGITS{7'h7F}};
            pend_en_q    <= '0;
            act_seg_q    <= {N_DIGITS{7'h7F}};
            act_en_q     <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            if (load) begin
                pend_seg_q <= seg_in;
                pend_en_q  <= digit_en;
            end
            if (swap) begin
                pend_valid_q <= 1'b0;
                if (load) begin
                    act_seg_q <= seg_in;
                    act_en_q  <= digit_en;
                end else if (pend_valid_q) begin
                    act_seg_q <= pend_seg_q;
                    act_en_q  <= pend_en_q;
                end
            end else if (load) begin
                pend_valid_q <= 1'b1;
            end
        end
    end

`ifdef SEG7_DIMMING_EN
    logic [31:0] dim_thr;
    assign dim_thr = ((32'(duty) + 32'd1) * 32'(REFRESH_DIV)) >> 4;
    assign lit     = (32'(div_q) < dim_thr);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        seg_d = 7'h7F;
        an_d  = '1;
        if (state_q == ST_SHOW && act_en_q[idx_q] && lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = act_seg_q[7*int'(idx_q) +: 7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux against a frame-position model
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int BC = 2;
`ifdef SEG7_DIMMING_EN
    localparam int RD = 16;
`else
    localparam int RD = 4;
`endif
    localparam int SLOT  = BC + RD;
    localparam int FRAME = ND * SLOT;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7*ND-1:0] seg_in = '0;
    logic [ND-1:0]   digit_en = '0;
    logic            load = 1'b0;
    logic [3:0]      duty = 4'hF;
    logic [6:0]      seg;
    logic [ND-1:0]   an;
    logic            frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0]    m_act_seg[ND];
    logic [6:0]    m_pend_seg[ND];
    logic [ND-1:0] m_act_en, m_pend_en;
    bit            m_pv;
    int            e;

    always #5 clk = ~clk;

    seg7_scan_mux #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_en(digit_en), .load(load),
`ifdef SEG7_DIMMING_EN
        .duty(duty),
`endif
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic model_reset();
        e    = 0;
        m_pv = 1'b0;
        m_act_en  = '0;
        m_pend_en = '0;
        for (int k = 0; k < ND; k++) begin
            m_act_seg[k]  = 7'h7F;
            m_pend_seg[k] = 7'h7F;
        end
    endtask

    // Model works from the frame position: slot = digit, first BC cycles of a slot are blank.
    task automatic tick();
        int            p, slot, ins;
        bit            on;
        logic [6:0]    es;
        logic [ND-1:0] ea;
        p    = e % FRAME;
        slot = p / SLOT;
        ins  = p % SLOT;
        es   = 7'h7F;
        ea   = '1;
        on   = (ins >= BC) && m_act_en[slot];
`ifdef SEG7_DIMMING_EN
        if ((ins - BC) >= (((int'(duty) + 1) * RD) >> 4)) on = 1'b0;
`endif
        if (on) begin
            ea[slot] = 1'b0;
            es       = m_act_seg[slot];
        end
        if (p == FRAME - 1) begin
            if (load) begin
                for (int k = 0; k < ND; k++) m_act_seg[k] = seg_in[7*k +: 7];
                m_act_en = digit_en;
            end else if (m_pv) begin
                m_act_seg = m_pend_seg;
                m_act_en  = m_pend_en;
            end
            m_pv = 1'b0;
        end else if (load) begin
            for (int k = 0; k < ND; k++) m_pend_seg[k] = seg_in[7*k +: 7];
            m_pend_en = digit_en;
            m_pv      = 1'b1;
        end
        @(posedge clk);
        e++;
        #1;
        chk("seg", 32'(seg), 32'(es));
        chk("an", 32'(an), 32'(ea));
        chk("frame_done", 32'(frame_done), 32'((e % FRAME) == FRAME - 1));
    endtask

    task automatic load_tick(input logic [7*ND-1:0] s, input logic [ND-1:0] en);
        seg_in   = s;
        digit_en = en;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("fd_wait", 32'(frame_done), 32'h1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // First frame after reset stays dark; pattern loaded mid-frame appears from next frame.
        for (int i = 0; i < 7; i++) tick();
        load_tick({7'h78, 7'h30, 7'h79, 7'h40}, 4'hF);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // New pattern during digit 2 SHOW: digits 2,3 keep old values this frame.
        while ((e % FRAME) != 2 * SLOT + BC + 1) tick();
        load_tick({7'h12, 7'h24, 7'h19, 7'h02}, 4'hF);
        for (int i = 0; i < FRAME + 4; i++) tick();

        // Disabled slots stay dark for their full time.
        load_tick({7'h00, 7'h11, 7'h22, 7'h33}, 4'b0101);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Load on the swap cycle goes live at once; a second load 3 cycles later waits a frame.
        wait_fd();
        load_tick({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF);
        for (int i = 0; i < 2; i++) tick();
        load_tick({7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'hE);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Two loads in one frame: only the last is shown.
        wait_fd();
        tick();
        load_tick({7'h01, 7'h02, 7'h04, 7'h08}, 4'hF);
        load_tick({7'h10, 7'h20, 7'h40, 7'h3F}, 4'hB);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Random loads with inputs churning between loads.
        for (int i = 0; i < 600; i++) begin
            seg_in   = {$urandom, $urandom};
            digit_en = ND'($urandom);
`ifdef SEG7_DIMMING_EN
            duty     = 4'($urandom);
`endif
            load     = ($urandom_range(0, 15) == 0);
            tick();
            load     = 1'b0;
        end

        // Mid-run reset, then recover.
        for (int i = 0; i < $urandom_range(3, 20); i++) tick();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        load_tick({7'h79, 7'h40, 7'h78, 7'h30}, 4'hF);
        for (int i = 0; i < 3 * FRAME; i++) begin
            seg_in = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
